// File: rtl/ias_sequencer.sv
// ias_sequencer: multi-cycle control sequencer for the IAS datapath.
// Walks fetch / decode / execute / write-back, runs the left (IR) and right
// (IBR) instruction halves of each fetched word, stalls on memory wait
// states, times the multiplier and parks in HALT until reset.
module ias_sequencer #(
    parameter int OPCODE_W   = 8,
    parameter int MUL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                ac_negative,
    output logic                mem_read,
    output logic                mem_write,
    output logic                load_ir,
    output logic                load_ibr,
    output logic                increment_pc,
    output logic                load_pc,
    output logic                load_ac,
    output logic                load_mq,
    output logic [1:0]          alu_op,
    output logic                half_sel,
    output logic                halted,
    output logic                illegal_op
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(8'h01);
    localparam logic [OPCODE_W-1:0] OP_STOR  = OPCODE_W'(8'h21);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(8'h05);
    localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(8'h06);
    localparam logic [OPCODE_W-1:0] OP_LDMQM = OPCODE_W'(8'h09);
    localparam logic [OPCODE_W-1:0] OP_LDMQ  = OPCODE_W'(8'h0A);
    localparam logic [OPCODE_W-1:0] OP_MUL   = OPCODE_W'(8'h0B);
    localparam logic [OPCODE_W-1:0] OP_JMPL  = OPCODE_W'(8'h0D);
    localparam logic [OPCODE_W-1:0] OP_JMPR  = OPCODE_W'(8'h0E);
    localparam logic [OPCODE_W-1:0] OP_JPOSL = OPCODE_W'(8'h0F);
    localparam logic [OPCODE_W-1:0] OP_JPOSR = OPCODE_W'(8'h10);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(8'hFF);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MULWAIT,
        S_WRITE_BACK,
        S_HALT
    } state_t;

    state_t              state;
    logic                half;
    logic                start_half;
    logic                jump_taken;
    logic [OPCODE_W-1:0] op_reg;
    logic [CNT_W-1:0]    mul_cnt;
    logic                take_jump;

    // Jump decision for the latched opcode; conditional jumps look at the AC sign only here.
    always_comb begin
        take_jump = 1'b0;
        if (op_reg == OP_JMPL || op_reg == OP_JMPR)
            take_jump = 1'b1;
        else if (op_reg == OP_JPOSL || op_reg == OP_JPOSR)
            take_jump = ~ac_negative;
    end

    // Sequencer state, instruction-half tracking and multiplier countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            half       <= 1'b0;
            start_half <= 1'b0;
            jump_taken <= 1'b0;
            op_reg     <= '0;
            mul_cnt    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        half  <= start_half;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_reg <= opcode;
                    state  <= (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (op_reg)
                        OP_LOAD, OP_ADD, OP_SUB, OP_LDMQM, OP_STOR: begin
                            if (mem_ready)
                                state <= S_WRITE_BACK;
                        end
                        OP_MUL: begin
                            if (mem_ready) begin
                                mul_cnt <= CNT_W'(MUL_CYCLES);
                                state   <= S_MULWAIT;
                            end
                        end
                        OP_JMPL, OP_JPOSL: begin
                            if (take_jump) begin
                                jump_taken <= 1'b1;
                                start_half <= 1'b0;
                            end
                            state <= S_WRITE_BACK;
                        end
                        OP_JMPR, OP_JPOSR: begin
                            if (take_jump) begin
                                jump_taken <= 1'b1;
                                start_half <= 1'b1;
                            end
                            state <= S_WRITE_BACK;
                        end
                        default: state <= S_WRITE_BACK;
                    endcase
                end
                S_MULWAIT: begin
                    mul_cnt <= mul_cnt - CNT_W'(1);
                    if (mul_cnt == CNT_W'(1))
                        state <= S_WRITE_BACK;
                end
                S_WRITE_BACK: begin
                    if (jump_taken) begin
                        jump_taken <= 1'b0;
                        state      <= S_FETCH;
                    end else if (!half) begin
                        // Right half is already sitting in IBR: no fetch needed.
                        half  <= 1'b1;
                        state <= S_DECODE;
                    end else begin
                        start_half <= 1'b0;
                        state      <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Control strobes decoded from state; reset forces them all low immediately.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        load_ir      = 1'b0;
        load_ibr     = 1'b0;
        increment_pc = 1'b0;
        load_pc      = 1'b0;
        load_ac      = 1'b0;
        load_mq      = 1'b0;
        alu_op       = 2'b00;
        half_sel     = 1'b0;
        halted       = 1'b0;
        illegal_op   = 1'b0;
        if (!reset) begin
            half_sel = half;
            case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        load_ir      = 1'b1;
                        load_ibr     = 1'b1;
                        increment_pc = 1'b1;
                    end
                end
                S_EXECUTE: begin
                    case (op_reg)
                        OP_LOAD: begin
                            mem_read = 1'b1;
                            load_ac  = mem_ready;
                        end
                        OP_ADD: begin
                            mem_read = 1'b1;
                            load_ac  = mem_ready;
                            alu_op   = mem_ready ? 2'b01 : 2'b00;
                        end
                        OP_SUB: begin
                            mem_read = 1'b1;
                            load_ac  = mem_ready;
                            alu_op   = mem_ready ? 2'b10 : 2'b00;
                        end
                        OP_LDMQM: begin
                            mem_read = 1'b1;
                            load_mq  = mem_ready;
                        end
                        OP_STOR:  mem_write = 1'b1;
                        OP_LDMQ:  load_ac   = 1'b1;
                        OP_MUL:   mem_read  = 1'b1;
                        OP_JMPL, OP_JMPR, OP_JPOSL, OP_JPOSR: load_pc = take_jump;
                        default:  illegal_op = 1'b1;
                    endcase
                end
                S_MULWAIT: begin
                    if (mul_cnt == CNT_W'(1)) begin
                        load_ac = 1'b1;
                        load_mq = 1'b1;
                        alu_op  = 2'b11;
                    end
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ias_sequencer.sv
// Directed bench for ias_sequencer: drives instruction words and memory
// handshakes cycle by cycle and compares every control output against
// hand-worked expectations.
module tb_ias_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] opcode;
    logic       mem_ready;
    logic       ac_negative;
    logic       mem_read, mem_write, load_ir, load_ibr, increment_pc, load_pc;
    logic       load_ac, load_mq, half_sel, halted, illegal_op;
    logic [1:0] alu_op;

    logic [7:0] left_op;
    logic [7:0] right_op;

    int n_vec = 0;
    int n_bad = 0;
    int cyc_no = 0;

    // Output bit map: {rd, wr, ir, ibr, inc, lpc, lac, lmq, alu[1:0], half, halted, ill}
    localparam logic [12:0] RD    = 13'h1000;
    localparam logic [12:0] WR    = 13'h0800;
    localparam logic [12:0] IRB   = 13'h0600;
    localparam logic [12:0] INC   = 13'h0100;
    localparam logic [12:0] LPC   = 13'h0080;
    localparam logic [12:0] LAC   = 13'h0040;
    localparam logic [12:0] LMQ   = 13'h0020;
    localparam logic [12:0] A_ADD = 13'h0008;
    localparam logic [12:0] A_SUB = 13'h0010;
    localparam logic [12:0] A_MUL = 13'h0018;
    localparam logic [12:0] HS    = 13'h0004;
    localparam logic [12:0] HLT   = 13'h0002;
    localparam logic [12:0] ILL   = 13'h0001;
    localparam logic [12:0] FDONE = RD | IRB | INC;
    localparam logic [12:0] NONE  = 13'h0000;

    logic [12:0] outs;
    assign outs = {mem_read, mem_write, load_ir, load_ibr, increment_pc, load_pc,
                   load_ac, load_mq, alu_op, half_sel, halted, illegal_op};

    // Datapath mux: the selected half of the fetched word feeds opcode.
    assign opcode = half_sel ? right_op : left_op;

    always #5 clk = ~clk;

    ias_sequencer #(.OPCODE_W(8), .MUL_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .ac_negative(ac_negative), .mem_read(mem_read), .mem_write(mem_write),
        .load_ir(load_ir), .load_ibr(load_ibr), .increment_pc(increment_pc),
        .load_pc(load_pc), .load_ac(load_ac), .load_mq(load_mq), .alu_op(alu_op),
        .half_sel(half_sel), .halted(halted), .illegal_op(illegal_op)
    );

    task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %b expected %b", tag, cyc_no, got, exp);
        end
    endtask

    // One clock: apply mem_ready, check the settled outputs, advance past the edge.
    task automatic cyc(input logic rdy, input logic [12:0] exp, input string tag);
        mem_ready = rdy;
        #1;
        check_eq(tag, outs, exp);
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic word(input logic [7:0] l, input logic [7:0] r);
        left_op  = l;
        right_op = r;
    endtask

    initial begin
        reset       = 1'b1;
        mem_ready   = 1'b0;
        ac_negative = 1'b0;
        word(8'h01, 8'h05);
        #1;
        check_eq("reset_idle", outs, NONE);
        mem_ready = 1'b1;
        #1;
        check_eq("reset_ready", outs, NONE);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // {LOAD, ADD} with zero-wait memory
        cyc(1, FDONE,              "ld_fetch");
        cyc(1, NONE,               "ld_decode");
        cyc(1, RD | LAC,           "ld_exec");
        cyc(1, NONE,               "ld_wb");
        cyc(1, HS,                 "add_decode");
        cyc(1, RD | LAC | A_ADD | HS, "add_exec");
        cyc(1, HS,                 "add_wb");

        // {LOAD with 3 wait states, SUB}
        word(8'h01, 8'h06);
        cyc(1, FDONE | HS,         "w2_fetch");
        cyc(1, NONE,               "w2_decode");
        cyc(0, RD,                 "ld_wait1");
        cyc(0, RD,                 "ld_wait2");
        cyc(0, RD,                 "ld_wait3");
        cyc(1, RD | LAC,           "ld_wait_done");
        cyc(1, NONE,               "w2_wb");
        cyc(1, HS,                 "sub_decode");
        cyc(1, RD | LAC | A_SUB | HS, "sub_exec");
        cyc(1, HS,                 "sub_wb");

        // Fetch with one wait state, {JPOSR taken, LDMQ}
        cyc(0, RD | HS,            "fetch_wait");
        word(8'h10, 8'h0A);
        cyc(1, FDONE | HS,         "w3_fetch");
        cyc(1, NONE,               "jposr_decode");
        cyc(1, LPC,                "jposr_taken");
        cyc(1, NONE,               "jposr_wb");

        // Jump target word {STOR, MUL}: left half skipped, MUL from IBR
        word(8'h21, 8'h0B);
        cyc(1, FDONE,              "tgt_fetch");
        cyc(1, HS,                 "tgt_decode_right");
        cyc(0, RD | HS,            "mul_wait");
        cyc(1, RD | HS,            "mul_operand");
        cyc(1, HS,                 "mulwait4");
        cyc(0, HS,                 "mulwait3");
        cyc(1, HS,                 "mulwait2");
        cyc(1, LAC | LMQ | A_MUL | HS, "mul_result");
        cyc(1, HS,                 "mul_wb");

        // {JPOSR not taken, LDMQ}: next fetch starts at the left half again
        word(8'h10, 8'h0A);
        ac_negative = 1'b1;
        cyc(1, FDONE | HS,         "w5_fetch");
        cyc(1, NONE,               "w5_decode_left");
        cyc(1, NONE,               "jposr_not_taken");
        ac_negative = 1'b0;
        cyc(1, NONE,               "w5_wb");
        cyc(1, HS,                 "ldmq_decode");
        cyc(1, LAC | HS,           "ldmq_exec");
        cyc(1, HS,                 "ldmq_wb");

        // {STOR with a wait, illegal 0x7E}
        word(8'h21, 8'h7E);
        cyc(1, FDONE | HS,         "w6_fetch");
        cyc(1, NONE,               "stor_decode");
        cyc(0, WR,                 "stor_wait");
        cyc(1, WR,                 "stor_done");
        cyc(1, NONE,               "stor_wb");
        cyc(1, HS,                 "ill_decode");
        cyc(1, ILL | HS,           "ill_exec");
        cyc(1, HS,                 "ill_wb");

        // {JMPL, x} then {HALT, LOAD}
        word(8'h0D, 8'h01);
        cyc(1, FDONE | HS,         "w7_fetch");
        cyc(1, NONE,               "jmpl_decode");
        cyc(1, LPC,                "jmpl_exec");
        cyc(1, NONE,               "jmpl_wb");
        word(8'hFF, 8'h01);
        cyc(1, FDONE,              "w8_fetch");
        cyc(1, NONE,               "halt_decode");
        for (int i = 0; i < 5; i++)
            cyc(logic'(i[0]), HLT, "halt_hold");

        // Reset while in MULWAIT with {MUL, LOAD}
        reset = 1'b1;
        #1;
        check_eq("halt_reset", outs, NONE);
        @(posedge clk);
        #1;
        reset = 1'b0;
        word(8'h0B, 8'h01);
        cyc(1, FDONE,              "w9_fetch");
        cyc(1, NONE,               "w9_decode");
        cyc(1, RD,                 "w9_mul_operand");
        cyc(1, NONE,               "w9_mulwait4");
        cyc(1, NONE,               "w9_mulwait3");
        mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        check_eq("mulwait_reset", outs, NONE);
        #2;
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_eq("post_reset_fetch", outs, RD);
        @(posedge clk);
        #1;
        cyc(0, RD,                 "post_reset_wait");
        cyc(1, FDONE,              "post_reset_fetch_done");
        cyc(1, NONE,               "post_reset_decode");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
